// File: rtl/quantizer_stream.sv
// ============================================================================
// quantizer_stream
// ----------------------------------------------------------------------------
// Streaming MSB quantizer. Each accepted unsigned sample Y keeps its top k
// bits (k derived from cfg_bits) and has the rest zeroed, either by plain
// truncation or by round-half-up with saturation at the all-kept-ones code.
// Two-stage valid/ready pipeline feeding reconstruction / error-analysis
// logic. Absolute quantisation error and sample count are accumulated over
// output transfers for bit-depth sweeps.
//
// Ports
//   clk, reset    single rising-edge clock, synchronous active-high reset
//   in_valid      input sample valid
//   in_ready      input accept (transfer on in_valid && in_ready)
//   in_data       input sample Y [DATA_W]
//   cfg_bits      number of kept MSBs, captured with each accepted sample
//   cfg_round     0 = truncate, 1 = round-half-up, captured per sample
//   out_valid     output valid
//   out_ready     downstream accept (transfer on out_valid && out_ready)
//   out_data      quantised sample Y_hat [DATA_W]
//   stats_clear   synchronous clear of err_sum / sample_cnt (wins over update)
//   err_sum       saturating sum of |Y - Y_hat| over output transfers [ERR_W]
//   sample_cnt    saturating count of output transfers [CNT_W]
// ============================================================================
module quantizer_stream #(
   parameter int DATA_W = 32,
   parameter int BITS_W = 6,
   parameter int CNT_W  = 16,
   parameter int ERR_W  = 48
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [BITS_W-1:0] cfg_bits,
   input  logic              cfg_round,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              stats_clear,
   output logic [ERR_W-1:0]  err_sum,
   output logic [CNT_W-1:0]  sample_cnt
);

   localparam int STAGES = 2;

   typedef logic [DATA_W-1:0] word_t;

   // S1 payload: raw sample plus its per-sample quantiser setup, so a later
   // cfg change never touches samples already inside the pipe.
   typedef struct packed {
      word_t y;
      word_t mask;
      word_t inc;
   } s1_t;

   // S2 payload: what leaves the block and what feeds the statistics.
   typedef struct packed {
      word_t yhat;
      word_t err;
   } s2_t;

   // vld_pipe[1] = S1 valid, vld_pipe[STAGES] = out_valid
   logic [STAGES:1] vld_pipe;
   s1_t             s1_q, s1_nxt;
   s2_t             s2_q, s2_nxt;
   logic            adv;

   // -------------------------------------------------------------------------
   // Input side: effective bit count, keep-mask and rounding increment
   // -------------------------------------------------------------------------
   logic [BITS_W-1:0] k;
   word_t             ones;

   assign ones = '1;

   // k is clamped to 1..DATA_W; zero kept bits is treated as one.
   always_comb begin
      if (cfg_bits == '0)
         k = BITS_W'(1);
      else if (int'(cfg_bits) >= DATA_W)
         k = BITS_W'(DATA_W);
      else
         k = cfg_bits;
   end

   always_comb begin
      s1_nxt      = '0;
      s1_nxt.y    = in_data;
      // k == DATA_W shifts everything out, giving an all-ones (pass) mask.
      s1_nxt.mask = ~(ones >> k);
      // Half an LSB of the kept field; no rounding when nothing is dropped.
      if (cfg_round && (int'(k) < DATA_W))
         s1_nxt.inc = word_t'(1) << (DATA_W - 1 - int'(k));
      else
         s1_nxt.inc = '0;
   end

   // -------------------------------------------------------------------------
   // S1 -> S2 datapath: round, saturate, mask, absolute error
   // -------------------------------------------------------------------------
   logic [DATA_W:0] rsum;

   always_comb begin
      s2_nxt = '0;
      rsum   = {1'b0, s1_q.y} + {1'b0, s1_q.inc};
      // Carry out of the rounded sum means Y was already in the top code:
      // clamp to all kept bits set rather than wrapping to zero.
      if (rsum[DATA_W])
         s2_nxt.yhat = s1_q.mask;
      else
         s2_nxt.yhat = rsum[DATA_W-1:0] & s1_q.mask;
      if (s2_nxt.yhat >= s1_q.y)
         s2_nxt.err = s2_nxt.yhat - s1_q.y;
      else
         s2_nxt.err = s1_q.y - s2_nxt.yhat;
   end

   // -------------------------------------------------------------------------
   // Pipeline control: the whole pipe moves together whenever the output
   // register is free or being drained this cycle.
   // -------------------------------------------------------------------------
   assign adv      = !vld_pipe[STAGES] || out_ready;
   assign in_ready = adv;

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
         s1_q     <= '0;
         s2_q     <= '0;
      end else if (adv) begin
         vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
         // Payload registers only load with real data, which keeps out_data
         // at its last delivered value through bubbles.
         if (in_valid)
            s1_q <= s1_nxt;
         if (vld_pipe[1])
            s2_q <= s2_nxt;
      end
   end

   assign out_valid = vld_pipe[STAGES];
   assign out_data  = s2_q.yhat;

   // -------------------------------------------------------------------------
   // Statistics over output transfers
   // -------------------------------------------------------------------------
   logic           xfer;
   logic [ERR_W:0] err_ext;

   assign xfer    = out_valid && out_ready;
   assign err_ext = {1'b0, err_sum} + (ERR_W+1)'(s2_q.err);

   always_ff @(posedge clk) begin
      if (reset || stats_clear) begin
         err_sum    <= '0;
         sample_cnt <= '0;
      end else if (xfer) begin
         err_sum <= err_ext[ERR_W] ? '1 : err_ext[ERR_W-1:0];
         if (sample_cnt != '1)
            sample_cnt <= sample_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_quantizer_stream.sv
module tb_quantizer_stream;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [5:0]  cfg_bits;
   logic        cfg_round;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        stats_clear;
   logic [47:0] err_sum;
   logic [15:0] sample_cnt;

   int vectors    = 0;
   int miscompares = 0;

   logic [47:0] exp_sum = '0;
   logic [15:0] exp_cnt = '0;

   quantizer_stream #(
      .DATA_W(32), .BITS_W(6), .CNT_W(16), .ERR_W(48)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .cfg_bits   (cfg_bits),
      .cfg_round  (cfg_round),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .stats_clear(stats_clear),
      .err_sum    (err_sum),
      .sample_cnt (sample_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one sample for one cycle (out_ready is high, so it is taken),
   // then scramble the config to show it was captured with the sample.
   task automatic send(input logic [31:0] d, input logic [5:0] b, input logic r);
      in_valid  = 1'b1;
      in_data   = d;
      cfg_bits  = b;
      cfg_round = r;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_data   = 32'hA5A5_A5A5;
      cfg_bits  = 6'd3;
      cfg_round = ~r;
   endtask

   // Single sample through an idle pipe: check latency, value, then stats.
   task automatic one(input string tag, input logic [31:0] d, input logic [5:0] b,
                      input logic r, input logic [31:0] exp_q, input logic [31:0] exp_e);
      send(d, b, r);
      chk({tag, "_lat1"}, out_valid, 1'b0);
      @(posedge clk); #1;
      chk({tag, "_valid"}, out_valid, 1'b1);
      chk({tag, "_data"}, out_data, exp_q);
      @(posedge clk); #1;
      exp_sum = exp_sum + 48'(exp_e);
      exp_cnt = exp_cnt + 16'd1;
      chk({tag, "_drain"}, out_valid, 1'b0);
      chk({tag, "_errsum"}, err_sum, exp_sum);
      chk({tag, "_cnt"}, sample_cnt, exp_cnt);
   endtask

   initial begin
      int  si;
      int  oi;
      logic acc;

      reset       = 1'b1;
      in_valid    = 1'b0;
      in_data     = '0;
      cfg_bits    = '0;
      cfg_round   = 1'b0;
      out_ready   = 1'b1;
      stats_clear = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_err_sum", err_sum, 48'h0);
      chk("rst_cnt", sample_cnt, 16'h0);
      chk("rst_in_ready", in_ready, 1'b1);

      // Directed single-sample vectors
      one("t16",   32'h1234_5678, 6'd16, 1'b0, 32'h1234_0000, 32'h0000_5678);
      one("r8up",  32'h1280_0000, 6'd8,  1'b1, 32'h1300_0000, 32'h0080_0000);
      one("r8dn",  32'h127F_FFFF, 6'd8,  1'b1, 32'h1200_0000, 32'h007F_FFFF);
      one("r4sat", 32'hF800_0000, 6'd4,  1'b1, 32'hF000_0000, 32'h0800_0000);
      one("t1",    32'h8000_0001, 6'd1,  1'b0, 32'h8000_0000, 32'h0000_0001);
      one("t0",    32'hC000_0000, 6'd0,  1'b0, 32'h8000_0000, 32'h4000_0000);
      one("r0sat", 32'hC000_0000, 6'd0,  1'b1, 32'h8000_0000, 32'h4000_0000);
      one("b40",   32'hDEAD_BEEF, 6'd40, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000);
      one("b32",   32'hFFFF_FFFF, 6'd32, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000);
      chk("sum_total", err_sum, 48'h8900_5678);

      // Clear without a transfer
      stats_clear = 1'b1;
      @(posedge clk); #1;
      stats_clear = 1'b0;
      chk("clr_sum", err_sum, 48'h0);
      chk("clr_cnt", sample_cnt, 16'h0);

      // Stream 0..9, out_ready low in cycles 3..7
      si = 0;
      oi = 0;
      for (int cyc = 0; cyc < 40 && oi < 10; cyc++) begin
         out_ready = !(cyc >= 3 && cyc <= 7);
         in_valid  = (si < 10);
         in_data   = (32'(si) << 8) | 32'h0000_000F;
         cfg_bits  = 6'd24;
         cfg_round = 1'b0;
         #1;
         acc = in_valid && in_ready;
         if (!out_ready) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_in_ready", in_ready, 1'b0);
         end
         if (out_valid) begin
            chk("stream_data", out_data, 32'(oi) << 8);
            if (out_ready) oi++;
         end
         @(posedge clk); #1;
         if (acc) si++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stream_count", 32'(oi), 32'd10);
      chk("stream_accepted", 32'(si), 32'd10);
      chk("stream_cnt", sample_cnt, 16'd10);
      chk("stream_errsum", err_sum, 48'h96);
      #1;
      chk("stream_nodup", out_valid, 1'b0);

      // stats_clear coincident with a transfer
      send(32'h0000_FFFF, 6'd16, 1'b0);
      @(posedge clk); #1;
      chk("clrx_valid", out_valid, 1'b1);
      chk("clrx_data", out_data, 32'h0);
      stats_clear = 1'b1;
      @(posedge clk); #1;
      stats_clear = 1'b0;
      chk("clrx_sum", err_sum, 48'h0);
      chk("clrx_cnt", sample_cnt, 16'h0);
      chk("clrx_drained", out_valid, 1'b0);

      // Reset mid-stream
      in_valid  = 1'b1;
      in_data   = 32'hAAAA_0000;
      cfg_bits  = 6'd16;
      cfg_round = 1'b0;
      @(posedge clk); #1;
      in_data = 32'hBBBB_0000;
      @(posedge clk); #1;
      chk("mid_valid", out_valid, 1'b1);
      chk("mid_data", out_data, 32'hAAAA_0000);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mrst_valid", out_valid, 1'b0);
      chk("mrst_data", out_data, 32'h0);
      chk("mrst_cnt", sample_cnt, 16'h0);
      reset    = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("mrst_nostale", out_valid, 1'b0);
      end
      chk("mrst_in_ready", in_ready, 1'b1);
      chk("mrst_cnt_after", sample_cnt, 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
